// File: rtl/lcd12864_pkg.sv
// lcd12864_pkg: shared definitions for the LCD text streamer.
//   - lcd_state_t    : streamer FSM states
//   - INIT_CMDS      : power-up command sequence, index 0 sent first
//   - ROW_ADDR_TABLE : DDRAM set-address command for each text row
//   - lowest_dirty() : picks the lowest-index row that needs redrawing
package lcd12864_pkg;

  typedef enum logic [2:0] {
    INIT_CMD = 3'd0,
    CLR_WAIT = 3'd1,
    IDLE     = 3'd2,
    ROW_ADDR = 3'd3,
    ROW_DATA = 3'd4
  } lcd_state_t;

  localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;
  localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CHAR_BLANK       = 8'h20;

  // Element [0] is sent first.
  localparam logic [3:0][7:0] INIT_CMDS =
    {CMD_CLEAR, CMD_ENTRY_MODE, CMD_DISPLAY_ON, CMD_FUNCTION_SET};

  // Rows 0..3 start at DDRAM 0x00/0x10/0x08/0x18 on this controller.
  localparam logic [3:0][7:0] ROW_ADDR_TABLE = {8'h98, 8'h88, 8'h90, 8'h80};

  function automatic logic [1:0] lowest_dirty(input logic [3:0] dirty);
    logic [1:0] row;
    if (dirty[0]) begin
      row = 2'd0;
    end else if (dirty[1]) begin
      row = 2'd1;
    end else if (dirty[2]) begin
      row = 2'd2;
    end else begin
      row = 2'd3;
    end
    return row;
  endfunction

endpackage

// File: rtl/lcd_char_ram.sv
// lcd_char_ram: 64-byte character buffer (4 rows x 16 columns) plus one
// dirty bit per row.
//   wr_en/wr_addr/wr_data : host write port, always accepted
//   wr_mark               : the host write also marks its row dirty
//   rd_addr/rd_data       : asynchronous read, forwards a same-cycle write
//   set_all               : mark every row dirty
//   clr_en/clr_row        : clear one row's dirty bit (a write to it wins)
//   dirty                 : current dirty bits
module lcd_char_ram #(
  parameter int NUM_ROWS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [5:0]          wr_addr,
  input  logic [7:0]          wr_data,
  input  logic                wr_mark,
  input  logic [5:0]          rd_addr,
  output logic [7:0]          rd_data,
  input  logic                set_all,
  input  logic                clr_en,
  input  logic [1:0]          clr_row,
  output logic [NUM_ROWS-1:0] dirty
);
  import lcd12864_pkg::*;

  logic [7:0]          mem_r [64];
  logic [NUM_ROWS-1:0] dirty_r;
  logic [NUM_ROWS-1:0] clr_mask_s;
  logic [NUM_ROWS-1:0] set_mask_s;

  // Character storage: blanks after reset, host writes land immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin
        mem_r[i] <= CHAR_BLANK;
      end
    end else if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // A byte loaded in the same cycle as a write to it sees the new value.
  assign rd_data = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem_r[rd_addr];

  // Set/clear masks; set is applied after clear so a write beats the clear.
  always_comb begin
    clr_mask_s = '0;
    set_mask_s = '0;
    if (clr_en) begin
      clr_mask_s[clr_row] = 1'b1;
    end else begin
      clr_mask_s = '0;
    end
    if (set_all) begin
      set_mask_s = '1;
    end else if (wr_mark) begin
      set_mask_s[wr_addr[5:4]] = 1'b1;
    end else begin
      set_mask_s = '0;
    end
  end

  // Dirty bit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dirty_r <= '0;
    end else begin
      dirty_r <= (dirty_r & ~clr_mask_s) | set_mask_s;
    end
  end

  assign dirty = dirty_r;

endmodule

// File: rtl/lcd_text_streamer.sv
// lcd_text_streamer: keeps a 4x16 text buffer and streams changed rows to an
// LCD bus driver over a valid/ready byte interface.
//   clk, rst_n          : clock, asynchronous active-low reset
//   wr_en/addr/data     : host character writes ([5:4] row, [3:0] column)
//   refresh             : redraw every row (ignored until init_done)
//   out_valid/rs/byte   : registered byte to the driver, rs=1 for characters
//   out_ready           : driver accepts the byte on this edge
//   init_done           : power-up commands and clear wait have finished
//   busy                : some row is dirty or a row is being streamed
module lcd_text_streamer #(
  parameter int CLR_WAIT = 80000,
  parameter int NUM_ROWS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       refresh,
  output logic       out_valid,
  output logic       out_rs,
  output logic [7:0] out_byte,
  input  logic       out_ready,
  output logic       init_done,
  output logic       busy
);
  import lcd12864_pkg::*;

  // The parameter CLR_WAIT shadows the state name, so states are scoped.
  localparam int WAIT_W = (CLR_WAIT > 1) ? $clog2(CLR_WAIT) : 1;

  lcd_state_t          state_r;
  logic [1:0]          init_idx_r;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic [1:0]          row_r;
  logic [3:0]          col_r;
  logic [3:0]          rd_col_s;
  logic [7:0]          rd_data_s;
  logic [NUM_ROWS-1:0] dirty_s;
  logic                wait_done_s;
  logic                set_all_s;
  logic                clr_en_s;

  assign wait_done_s = (wait_cnt_r == WAIT_W'(CLR_WAIT - 1));
  assign set_all_s   = ((state_r == lcd12864_pkg::CLR_WAIT) && wait_done_s) ||
                       (refresh && init_done);
  // Address command is always valid in ROW_ADDR, so ready alone means accepted.
  assign clr_en_s    = (state_r == lcd12864_pkg::ROW_ADDR) && out_ready;
  assign busy        = (|dirty_s) || (state_r == lcd12864_pkg::ROW_ADDR) ||
                       (state_r == lcd12864_pkg::ROW_DATA);

  // Column of the next character to load into out_byte.
  always_comb begin
    rd_col_s = col_r + 4'd1;
    if (state_r == lcd12864_pkg::ROW_ADDR) begin
      rd_col_s = 4'd0;
    end else begin
      rd_col_s = col_r + 4'd1;
    end
  end

  lcd_char_ram #(.NUM_ROWS(NUM_ROWS)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_mark (wr_en && init_done),
    .rd_addr ({row_r, rd_col_s}),
    .rd_data (rd_data_s),
    .set_all (set_all_s),
    .clr_en  (clr_en_s),
    .clr_row (row_r),
    .dirty   (dirty_s)
  );

  // Streamer FSM; out_* hold until the driver accepts them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= lcd12864_pkg::INIT_CMD;
      init_idx_r <= 2'd0;
      wait_cnt_r <= '0;
      row_r      <= 2'd0;
      col_r      <= 4'd0;
      out_valid  <= 1'b0;
      out_rs     <= 1'b0;
      out_byte   <= 8'h00;
      init_done  <= 1'b0;
    end else begin
      case (state_r)
        lcd12864_pkg::INIT_CMD: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_rs    <= 1'b0;
            out_byte  <= INIT_CMDS[init_idx_r];
          end else if (out_ready) begin
            if (init_idx_r == 2'd3) begin
              out_valid  <= 1'b0;
              init_idx_r <= 2'd0;
              wait_cnt_r <= '0;
              state_r    <= lcd12864_pkg::CLR_WAIT;
            end else begin
              init_idx_r <= init_idx_r + 2'd1;
              out_byte   <= INIT_CMDS[init_idx_r + 2'd1];
            end
          end
        end
        lcd12864_pkg::CLR_WAIT: begin
          if (wait_done_s) begin
            wait_cnt_r <= '0;
            init_done  <= 1'b1;
            state_r    <= lcd12864_pkg::IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
          end
        end
        lcd12864_pkg::IDLE: begin
          if (|dirty_s) begin
            row_r     <= lowest_dirty(dirty_s);
            out_valid <= 1'b1;
            out_rs    <= 1'b0;
            out_byte  <= ROW_ADDR_TABLE[lowest_dirty(dirty_s)];
            state_r   <= lcd12864_pkg::ROW_ADDR;
          end
        end
        lcd12864_pkg::ROW_ADDR: begin
          if (out_ready) begin
            col_r    <= 4'd0;
            out_rs   <= 1'b1;
            out_byte <= rd_data_s;
            state_r  <= lcd12864_pkg::ROW_DATA;
          end
        end
        lcd12864_pkg::ROW_DATA: begin
          if (out_ready) begin
            if (col_r == 4'd15) begin
              out_valid <= 1'b0;
              col_r     <= 4'd0;
              state_r   <= lcd12864_pkg::IDLE;
            end else begin
              col_r    <= col_r + 4'd1;
              out_byte <= rd_data_s;
            end
          end
        end
        default: begin
          state_r    <= lcd12864_pkg::INIT_CMD;
          init_idx_r <= 2'd0;
          out_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_streamer.sv
// Self-checking bench for lcd_text_streamer: a model of the character buffer
// and of the LCD screen (fed from every accepted byte) supply expectations.
module tb_lcd_text_streamer;
  localparam int CLR_W = 10;

  logic       clk = 1'b0;
  logic       rst_n, wr_en, refresh, out_ready;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       out_valid, out_rs, init_done, busy;
  logic [7:0] out_byte;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int init_rise_cyc = -1;
  logic [8:0] acc_q[$];
  int         acc_cyc[$];
  logic [8:0] exp_q[$];
  logic [7:0] buf_m [64];
  logic [7:0] disp [64];
  int cur_row = 0;
  int cur_col = 0;
  logic [7:0] addr_tbl [4];
  logic [7:0] init_tbl [4];
  logic       prev_stall = 1'b0;
  logic [8:0] prev_out = 9'd0;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
    logic [7:0] exp_cmd;
    int         exp_col;
  } vec_t;
  vec_t vecs [5];

  lcd_text_streamer #(.CLR_WAIT(CLR_W), .NUM_ROWS(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .refresh(refresh), .out_valid(out_valid),
    .out_rs(out_rs), .out_byte(out_byte), .out_ready(out_ready),
    .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Screen model: address commands move the cursor, characters fill it.
  function automatic void apply_lcd(input logic rs, input logic [7:0] b);
    if (rs) begin
      disp[cur_row*16 + cur_col] = b;
      cur_col = (cur_col + 1) % 16;
    end else if (b == 8'h01) begin
      foreach (disp[i]) disp[i] = 8'h20;
      cur_row = 0;
      cur_col = 0;
    end else begin
      for (int r = 0; r < 4; r++) if (b == addr_tbl[r]) begin cur_row = r; cur_col = 0; end
    end
  endfunction

  // Transfer monitor: sampled mid-cycle, a valid&&ready here transfers at the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", 32'({out_valid, out_rs, out_byte}), 32'({1'b1, prev_out}));
      prev_stall = out_valid && !out_ready;
      prev_out = {out_rs, out_byte};
      if (init_done && init_rise_cyc < 0) init_rise_cyc = cyc;
      if (out_valid && out_ready) begin
        acc_q.push_back({out_rs, out_byte});
        acc_cyc.push_back(cyc);
        apply_lcd(out_rs, out_byte);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    buf_m[a] = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    step();
    refresh = 1'b0;
  endtask

  task automatic wait_acc(input int n);
    for (int i = 0; i < 2000; i++) begin
      if (acc_q.size() >= n) return;
      step();
    end
    chk("timeout_acc", 32'(acc_q.size()), 32'(n));
  endtask

  task automatic wait_idle(input bit rnd);
    for (int i = 0; i < 4000; i++) begin
      if (!busy && init_done) return;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    chk("timeout_idle", 32'(busy), 32'(0));
  endtask

  function automatic void clear_streams();
    acc_q.delete();
    acc_cyc.delete();
    exp_q.delete();
  endfunction

  function automatic void add_row(input int r);
    exp_q.push_back({1'b0, addr_tbl[r]});
    for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, buf_m[r*16 + c]});
  endfunction

  task automatic check_stream(input string name);
    chk({name, "_len"}, 32'(acc_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++)
      chk(name, 32'(acc_q[i]), 32'(exp_q[i]));
  endtask

  // Releases reset (stream queues empty, buf_m blank) and checks the start-up traffic.
  task automatic check_init();
    rst_n = 1'b1;
    step();
    chk("first_after_reset", 32'({out_valid, out_rs, out_byte}), 32'({1'b1, 1'b0, 8'h38}));
    wait_acc(4);
    for (int i = 0; i < 4 && i < acc_q.size(); i++)
      chk("init_cmd", 32'(acc_q[i]), 32'({1'b0, init_tbl[i]}));
    for (int i = 0; i < 200 && init_rise_cyc < 0; i++) step();
    if (acc_cyc.size() >= 4)
      chk("clr_wait_cycles", 32'(init_rise_cyc - (acc_cyc[3] + 1)), 32'(CLR_W));
    wait_idle(1'b0);
    if (acc_cyc.size() >= 5)
      chk("clr_gap_no_bytes", 32'((acc_cyc[4] - acc_cyc[3]) > CLR_W), 32'(1));
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, init_tbl[i]});
    for (int r = 0; r < 4; r++) add_row(r);
    check_stream("init_stream");
  endtask

  initial begin
    addr_tbl[0] = 8'h80; addr_tbl[1] = 8'h90; addr_tbl[2] = 8'h88; addr_tbl[3] = 8'h98;
    init_tbl[0] = 8'h38; init_tbl[1] = 8'h0C; init_tbl[2] = 8'h06; init_tbl[3] = 8'h01;
    vecs[0] = '{6'h25, 8'h41, 8'h88, 5};
    vecs[1] = '{6'h00, 8'h7E, 8'h80, 0};
    vecs[2] = '{6'h1F, 8'h5A, 8'h90, 15};
    vecs[3] = '{6'h3A, 8'h30, 8'h98, 10};
    vecs[4] = '{6'h2F, 8'h21, 8'h88, 15};
    foreach (buf_m[i]) buf_m[i] = 8'h20;
    foreach (disp[i]) disp[i] = 8'h00;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 6'd0; wr_data = 8'd0;
    refresh = 1'b0; out_ready = 1'b1;

    // Reset state
    step(); step();
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_rs", 32'(out_rs), 32'(0));
    chk("rst_byte", 32'(out_byte), 32'(0));
    chk("rst_init_done", 32'(init_done), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    check_init();

    // Single-character writes, one row redraw each
    foreach (vecs[k]) begin
      wait_idle(1'b0);
      clear_streams();
      do_write(vecs[k].addr, vecs[k].data);
      wait_idle(1'b0);
      chk("vec_len", 32'(acc_q.size()), 32'(17));
      if (acc_q.size() >= 17) begin
        chk("vec_cmd", 32'(acc_q[0]), 32'({1'b0, vecs[k].exp_cmd}));
        chk("vec_char", 32'(acc_q[1 + vecs[k].exp_col]), 32'({1'b1, vecs[k].data}));
      end
      chk("vec_busy", 32'(busy), 32'(0));
    end

    // Stall 1-0-0-1 in the middle of row 0
    for (int c = 0; c < 16; c++) do_write(6'(16 + c), 8'(8'h61 + c));
    wait_idle(1'b0);
    clear_streams();
    pulse_refresh();
    wait_acc(8);
    out_ready = 1'b0;
    step(); step();
    chk("stall_no_xfer", 32'(acc_q.size()), 32'(8));
    out_ready = 1'b1;
    wait_idle(1'b0);
    for (int r = 0; r < 4; r++) add_row(r);
    check_stream("stall_stream");

    // Write to row 1 col 3 while row 1 col 10 is presented
    clear_streams();
    do_write(6'h10, 8'h4D);
    wait_acc(11);
    add_row(1);
    do_write(6'h13, 8'h33);
    add_row(1);
    wait_idle(1'b0);
    check_stream("rewrite_stream");

    // Two refresh pulses while row 0 streams
    clear_streams();
    do_write(6'h02, 8'h52);
    wait_acc(3);
    pulse_refresh();
    wait_acc(10);
    pulse_refresh();
    wait_idle(1'b0);
    add_row(0);
    for (int r = 0; r < 4; r++) add_row(r);
    check_stream("refresh_stream");

    // Random writes, refreshes and backpressure; screen must converge to buffer
    for (int i = 0; i < 500; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      wr_en = 1'b0;
      refresh = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        wr_en = 1'b1;
        wr_addr = 6'($urandom);
        wr_data = 8'($urandom_range(33, 126));
        buf_m[wr_addr] = wr_data;
      end
      if ($urandom_range(0, 49) == 0) refresh = 1'b1;
      step();
    end
    wr_en = 1'b0;
    refresh = 1'b0;
    wait_idle(1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) chk("screen_vs_buffer", 32'(disp[i]), 32'(buf_m[i]));

    // Reset while row 0 col 7 is presented
    clear_streams();
    pulse_refresh();
    wait_acc(8);
    rst_n = 1'b0;
    #1;
    chk("midrow_rst_valid", 32'(out_valid), 32'(0));
    chk("midrow_rst_busy", 32'(busy), 32'(0));
    chk("midrow_rst_init_done", 32'(init_done), 32'(0));
    clear_streams();
    foreach (buf_m[i]) buf_m[i] = 8'h20;
    init_rise_cyc = -1;
    step(); step();
    check_init();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
